// File: rtl/mem_sram_ctrl_if.sv
// Pipeline-side and SRAM-side signals of the half-word SRAM controller.
// The controller uses the slave modport; the pipeline/SRAM model uses master.
interface mem_sram_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Result;
  logic [31:0] ST_Val;
  logic        ready;
  logic [31:0] Mem_Result;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic [15:0] SRAM_DQ_in;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_Result, ST_Val, SRAM_DQ_in,
    output ready, Mem_Result, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_Result, ST_Val, SRAM_DQ_in,
    input  ready, Mem_Result, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// 32-bit load/store to a 16-bit external SRAM in two half-word cycles (LO, HI),
// freezing the pipeline via ready. Optional wait states: define SRAM_WAIT_STATES_EN.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic           CLK,
  input logic           RST,
  mem_sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [16:0] index_q, index_d;
  logic [31:0] data_q, data_d;
  logic        wr_q, wr_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] result_q, result_d;
  logic        last_cycle;
  logic [16:0] word_index;

  // SRAM window starts at byte 1024; byte offset within the word is dropped.
  assign word_index = 17'((bus.ALU_Result - 32'd1024) >> 2);

`ifdef SRAM_WAIT_STATES_EN
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  logic [2:0] wait_q, wait_d;

  assign last_cycle = (wait_q == 3'd0);

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = WAIT_LOAD;
    end else if (wait_q != 3'd0) begin
      wait_d = wait_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign last_cycle = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    data_d   = data_q;
    wr_d     = wr_q;
    lo_d     = lo_q;
    result_d = result_q;

    bus.ready       = 1'b0;
    bus.SRAM_ADDR   = '0;
    bus.SRAM_DQ_out = '0;
    bus.SRAM_DQ_oe  = 1'b0;
    bus.SRAM_WE_N   = 1'b1;

    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.MEM_W_EN || bus.MEM_R_EN) begin
          bus.ready = 1'b0;
          index_d   = word_index;
          data_d    = bus.ST_Val;
          wr_d      = bus.MEM_W_EN;
          state_d   = LO;
        end
      end
      LO: begin
        bus.SRAM_ADDR = {index_q, 1'b0};
        if (wr_q) begin
          bus.SRAM_DQ_out = data_q[15:0];
          bus.SRAM_DQ_oe  = 1'b1;
          bus.SRAM_WE_N   = 1'b0;
        end
        if (last_cycle) begin
          if (!wr_q) begin
            lo_d = bus.SRAM_DQ_in;
          end
          state_d = HI;
        end
      end
      HI: begin
        bus.SRAM_ADDR = {index_q, 1'b1};
        if (wr_q) begin
          bus.SRAM_DQ_out = data_q[31:16];
          bus.SRAM_DQ_oe  = 1'b1;
          bus.SRAM_WE_N   = 1'b0;
        end
        if (last_cycle) begin
          // Result is only committed once both halves are in hand.
          if (!wr_q) begin
            result_d = {bus.SRAM_DQ_in, lo_q};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        bus.ready = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Safe bus state whenever reset is held, even mid-access.
    if (RST) begin
      bus.ready       = 1'b1;
      bus.SRAM_ADDR   = '0;
      bus.SRAM_DQ_out = '0;
      bus.SRAM_DQ_oe  = 1'b0;
      bus.SRAM_WE_N   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      index_q  <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign bus.Mem_Result = result_q;

  a_wait_range: assert property (@(posedge CLK) (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 7));
  a_done_to_idle: assert property (@(posedge CLK) disable iff (RST)
                                   (state_q == DONE) |=> (state_q == IDLE));
  a_we_drives_bus: assert property (@(posedge CLK) !bus.SRAM_WE_N |-> bus.SRAM_DQ_oe);

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl: stimulus pushes expected SRAM writes and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_sram_ctrl;

  localparam int WC = 2;
`ifdef SRAM_WAIT_STATES_EN
  localparam int W_EFF = WC;
`else
  localparam int W_EFF = 0;
`endif
  localparam int LAT = 3 + 2 * W_EFF;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } sram_exp_t;

  typedef struct {
    logic [31:0] result;
    int          lat;
    string       name;
  } done_exp_t;

  logic CLK;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  sram_exp_t   sram_q[$];
  done_exp_t   done_q[$];
  logic [31:0] exp_mem = 32'h0;

  logic [15:0] sram [0:1023];

  mem_sram_ctrl_if bus ();

  mem_sram_ctrl #(.WAIT_CYCLES(WC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External SRAM model: asynchronous read, write on the clock edge.
  assign bus.SRAM_DQ_in = bus.SRAM_DQ_oe ? 16'h0000 : sram[bus.SRAM_ADDR[9:0]];
  always @(posedge CLK) begin
    if (!bus.SRAM_WE_N) sram[bus.SRAM_ADDR[9:0]] <= bus.SRAM_DQ_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: one write-cycle check per strobe, one completion check per ready rise.
  logic prev_ready = 1'b1;
  int   low_cnt    = 0;
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
      end else begin
        if (!bus.SRAM_WE_N) begin
          if (sram_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=addr 0x%05h required=no write", bus.SRAM_ADDR);
          end else begin
            sram_exp_t e;
            e = sram_q.pop_front();
            check("write_addr", 32'(bus.SRAM_ADDR), 32'(e.addr));
            check("write_data", 32'(bus.SRAM_DQ_out), 32'(e.data));
            check("write_oe", 32'(bus.SRAM_DQ_oe), 32'd1);
          end
        end
        if (!bus.ready) begin
          low_cnt++;
        end else begin
          if (!prev_ready) begin
            if (done_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ready actual=ready rise required=none");
            end else begin
              done_exp_t d;
              d = done_q.pop_front();
              check({d.name, "_result"}, bus.Mem_Result, d.result);
              check({d.name, "_latency"}, 32'(low_cnt), 32'(d.lat));
              $display("txn %-16s Mem_Result=0x%08h stall=%0d", d.name, bus.Mem_Result, low_cnt);
            end
          end
          low_cnt = 0;
        end
        prev_ready = bus.ready;
      end
    end
  end

  task automatic drive_idle();
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_Result = 32'h0;
    bus.ST_Val     = 32'h0;
  endtask

  // Present one EX/MEM instruction, hold it while frozen, return just after it retires.
  task automatic issue(input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rd_word, input string name);
    logic [16:0] idx;
    done_exp_t   d;
    int          n;
    idx = 17'((addr - 32'd1024) >> 2);
    if (w) begin
      for (int k = 0; k <= W_EFF; k++) sram_q.push_back('{addr: {idx, 1'b0}, data: data[15:0]});
      for (int k = 0; k <= W_EFF; k++) sram_q.push_back('{addr: {idx, 1'b1}, data: data[31:16]});
    end else if (r) begin
      exp_mem = rd_word;
    end
    d.result = exp_mem;
    d.lat    = LAT;
    d.name   = name;
    done_q.push_back(d);
    bus.MEM_R_EN   = r;
    bus.MEM_W_EN   = w;
    bus.ALU_Result = addr;
    bus.ST_Val     = data;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.ready && n < 100);
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=ready low %0d cycles required=ready", name, n);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    RST = 1'b1;
    drive_idle();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("rst_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check("rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check("rst_dq_out", 32'(bus.SRAM_DQ_out), 32'd0);
    check("rst_mem_result", bus.Mem_Result, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Back-to-back write then read of the same word.
    issue(1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0, "wr_408");
    issue(1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'hDEAD_BEEF, "rd_408");
    drive_idle();
    @(posedge CLK);
    #1;
    // Both enables: write wins, load result untouched.
    issue(1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, "rdwr_400");
    issue(1'b1, 1'b0, 32'h0000_040B, 32'h0, 32'hDEAD_BEEF, "rd_40b");
    issue(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, "rd_400");
    // Address below the window wraps to the top SRAM word.
    issue(1'b0, 1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 32'h0, "wr_3fc");
    issue(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_C0DE, "rd_3fc");
    issue(1'b0, 1'b1, 32'h0000_0420, 32'h1234_5678, 32'h0, "wr_420");
    issue(1'b1, 1'b0, 32'h0000_0420, 32'h0, 32'h1234_5678, "rd_420");
    drive_idle();
    @(posedge CLK);
    #1;

    // Read aborted by reset during HI.
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_Result = 32'h0000_0408;
    @(posedge CLK);
    repeat (W_EFF) @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_rst_ready", 32'(bus.ready), 32'd1);
    check("abort_rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("abort_rst_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check("abort_rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
    drive_idle();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_mem = 32'h0;
    @(negedge CLK);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_mem_result", bus.Mem_Result, 32'd0);
    @(posedge CLK);
    #1;

    issue(1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'hDEAD_BEEF, "rd_408_post");
    drive_idle();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("sram_queue_empty", 32'(sram_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    check("idle_mem_result", bus.Mem_Result, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
